// File: rtl/tb_cmd_pkg.sv
// Shared types and constants for the scenario command sequencer.
// State encoding, keyword strings and the counter width live here.
package tb_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

    localparam string KW_SET = "SET";
    localparam string KW_WTR = "WTR";
    localparam string KW_WTF = "WTF";
    localparam string KW_CHK = "CHK";

    localparam int CNT_W = 16;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/tb_cmd_fifo.sv
// String-vector FIFO; pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate occupancy counter.
module tb_cmd_fifo
    import tb_cmd_pkg::*;
#(
    parameter int ARGS_NB    = 5,
    parameter int FIFO_DEPTH = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  logic  pop,
    input  string din  [ARGS_NB],
    output string dout [ARGS_NB],
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    string      mem_r [FIFO_DEPTH][ARGS_NB];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        push_ok_s;
    logic        pop_ok_s;

    // Status decode from the registered pointers.
    always_comb begin
        empty     = (wr_ptr_r == rd_ptr_r);
        full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
    end

    // Head entry presented to the reader.
    always_comb begin
        for (int j = 0; j < ARGS_NB; j++) begin
            dout[j] = mem_r[rd_ptr_r[AW-1:0]][j];
        end
    end

    // Pointer update; emptying the FIFO on reset only needs the pointers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            for (int j = 0; j < ARGS_NB; j++) begin
                mem_r[wr_ptr_r[AW-1:0]][j] <= din[j];
            end
        end
    end

endmodule

// File: rtl/tb_cmd_sequencer.sv
// Issues buffered scenario commands to the decoder one at a time, retiring
// each on ack or on timeout, and keeps run/health flags and counters.
module tb_cmd_sequencer
    import tb_cmd_pkg::*;
#(
    parameter int ARGS_NB        = 5,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  string            i_push_args [ARGS_NB],
    input  logic             i_start,
    output logic             o_full,
    output logic             o_empty,
    output string            o_args [ARGS_NB],
    output logic             o_args_valid,
    input  logic             i_ack,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
    output logic             o_overflow,
    output logic [CNT_W-1:0] o_cmd_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam int                TCNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);

    state_e             state_r;
    string              args_r [ARGS_NB];
    logic [TCNT_W-1:0]  tcnt_r;
    logic               valid_r;
    logic               done_r;
    logic               timeout_r;
    logic               overflow_r;
    logic [CNT_W-1:0]   cmd_cnt_r;
    logic [CNT_W-1:0]   err_cnt_r;
    logic               fifo_pop_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    string              fifo_dout_s [ARGS_NB];

    // The only pop happens in FETCH, which is entered only with data queued.
    always_comb begin
        fifo_pop_s = (state_r == ST_FETCH);
    end

    tb_cmd_fifo #(
        .ARGS_NB    (ARGS_NB),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (i_push),
        .pop   (fifo_pop_s),
        .din   (i_push_args),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Sequencer FSM with its timeout counter, flags and retire counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            tcnt_r     <= '0;
            valid_r    <= 1'b0;
            done_r     <= 1'b0;
            timeout_r  <= 1'b0;
            overflow_r <= 1'b0;
            cmd_cnt_r  <= '0;
            err_cnt_r  <= '0;
            for (int j = 0; j < ARGS_NB; j++) begin
                args_r[j] <= "";
            end
        end else begin
            done_r <= 1'b0;
            if (i_push && fifo_full_s) begin
                overflow_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (i_start && !fifo_empty_s) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    for (int j = 0; j < ARGS_NB; j++) begin
                        args_r[j] <= fifo_dout_s[j];
                    end
                    tcnt_r  <= '0;
                    valid_r <= 1'b1;
                    state_r <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    // Ack takes priority over a timeout landing on the same cycle.
                    if (i_ack || (tcnt_r == TCNT_LAST)) begin
                        valid_r <= 1'b0;
                        if (i_ack) begin
                            cmd_cnt_r <= cmd_cnt_r + CNT_W'(1);
                        end else begin
                            timeout_r <= 1'b1;
                            err_cnt_r <= sat_inc(err_cnt_r);
                        end
                        if (!fifo_empty_s) begin
                            state_r <= ST_FETCH;
                        end else begin
                            state_r <= ST_IDLE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        tcnt_r <= tcnt_r + TCNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Output mapping; everything below is a register or a decode of one.
    always_comb begin
        for (int j = 0; j < ARGS_NB; j++) begin
            o_args[j] = args_r[j];
        end
        o_full       = fifo_full_s;
        o_empty      = fifo_empty_s;
        o_args_valid = valid_r;
        o_busy       = (state_r != ST_IDLE);
        o_done       = done_r;
        o_timeout    = timeout_r;
        o_overflow   = overflow_r;
        o_cmd_cnt    = cmd_cnt_r;
        o_err_cnt    = err_cnt_r;
    end

endmodule

// File: tb/tb_tb_cmd_sequencer.sv
// Directed bench for tb_cmd_sequencer; each task drives one scenario and
// checks hand-computed expectations sampled 1 time unit after the clock edge.
module tb_tb_cmd_sequencer;
    import tb_cmd_pkg::*;

    localparam int ARGS = 5;
    localparam int DEPTH = 16;
    localparam int TMO = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_push = 1'b0;
    string       i_push_args [ARGS];
    logic        i_start = 1'b0;
    logic        o_full;
    logic        o_empty;
    string       o_args [ARGS];
    logic        o_args_valid;
    logic        i_ack = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic        o_timeout;
    logic        o_overflow;
    logic [15:0] o_cmd_cnt;
    logic [15:0] o_err_cnt;

    int n_tests = 0;
    int n_fail = 0;

    tb_cmd_sequencer #(
        .ARGS_NB        (ARGS),
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (i_push),
        .i_push_args  (i_push_args),
        .i_start      (i_start),
        .o_full       (o_full),
        .o_empty      (o_empty),
        .o_args       (o_args),
        .o_args_valid (o_args_valid),
        .i_ack        (i_ack),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_timeout    (o_timeout),
        .o_overflow   (o_overflow),
        .o_cmd_cnt    (o_cmd_cnt),
        .o_err_cnt    (o_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_args(input string kw, input int tag);
        i_push_args[0] = kw;
        for (int j = 1; j < ARGS; j++) i_push_args[j] = $sformatf("%0d_%0d", tag, j);
    endtask

    task automatic push_cmd(input string kw, input int tag);
        set_args(kw, tag);
        i_push = 1'b1;
        tick();
        i_push = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        n_tests++;
        if ({o_args_valid, o_busy, o_done, o_timeout, o_overflow, o_full, o_empty} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000001",
                     {o_args_valid, o_busy, o_done, o_timeout, o_overflow, o_full, o_empty});
        end
        n_tests++;
        if (o_cmd_cnt !== 16'd0 || o_err_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_counters: got cmd=%0d err=%0d expected 0/0", o_cmd_cnt, o_err_cnt);
        end
        n_tests++;
        if (o_args[0] != "" || o_args[4] != "") begin
            n_fail++;
            $display("FAIL reset_args: got '%s' '%s' expected empty", o_args[0], o_args[4]);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        string exp_kw [3];
        int    done_seen = 0;
        int    idx = 0;
        exp_kw[0] = KW_SET; exp_kw[1] = KW_CHK; exp_kw[2] = KW_SET;
        for (int i = 0; i < 3; i++) push_cmd(exp_kw[i], i);
        i_ack = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_tests++;
            if (o_args_valid !== ((k == 1) || (k == 3) || (k == 5))) begin
                n_fail++;
                $display("FAIL basic_valid_k%0d: got %b", k, o_args_valid);
            end
            if (o_args_valid === 1'b1 && idx < 3) begin
                n_tests++;
                if (o_args[0] != exp_kw[idx] || o_args[1] != $sformatf("%0d_1", idx)) begin
                    n_fail++;
                    $display("FAIL basic_args%0d: got %s %s expected %s %0d_1",
                             idx, o_args[0], o_args[1], exp_kw[idx], idx);
                end
                idx++;
            end
            if (o_done === 1'b1) begin
                done_seen++;
                n_tests++;
                if (k != 6) begin
                    n_fail++;
                    $display("FAIL basic_done_cycle: got k=%0d expected 6", k);
                end
            end
        end
        i_ack = 1'b0;
        n_tests++;
        if (done_seen != 1 || o_cmd_cnt !== 16'd3 || o_empty !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: got done=%0d cnt=%0d empty=%b busy=%b expected 1 3 1 0",
                     done_seen, o_cmd_cnt, o_empty, o_busy);
        end
    endtask

    task automatic test_overflow();
        int    issued = 0;
        int    done_seen = 0;
        string first_tag = "";
        string last_tag = "";
        for (int i = 0; i < 16; i++) push_cmd(KW_SET, i);
        n_tests++;
        if (o_full !== 1'b1 || o_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full16: got full=%b ovf=%b expected 1 0", o_full, o_overflow);
        end
        push_cmd(KW_SET, 16);
        n_tests++;
        if (o_full !== 1'b1 || o_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_17th: got full=%b ovf=%b expected 1 1", o_full, o_overflow);
        end
        i_ack = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 60 && done_seen == 0; k++) begin
            tick();
            if (o_args_valid === 1'b1) begin
                if (issued == 0) first_tag = o_args[1];
                last_tag = o_args[1];
                issued++;
            end
            if (o_done === 1'b1) done_seen = 1;
        end
        i_ack = 1'b0;
        n_tests++;
        if (done_seen != 1 || issued != 16 || first_tag != "0_1" || last_tag != "15_1") begin
            n_fail++;
            $display("FAIL ovf_drain: got done=%0d issued=%0d first=%s last=%s expected 1 16 0_1 15_1",
                     done_seen, issued, first_tag, last_tag);
        end
        n_tests++;
        if (o_cmd_cnt !== 16'd19) begin
            n_fail++;
            $display("FAIL ovf_cmd_cnt: got %0d expected 19", o_cmd_cnt);
        end
    endtask

    task automatic test_timeout();
        int vcnt = 0;
        push_cmd(KW_WTR, 0);
        push_cmd(KW_SET, 1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (o_args_valid === 1'b1) vcnt++;
        end
        n_tests++;
        if (vcnt != TMO || o_args_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_valid_len: got %0d cycles, valid=%b expected 10 0", vcnt, o_args_valid);
        end
        n_tests++;
        if (o_timeout !== 1'b1 || o_err_cnt !== 16'd1 || o_cmd_cnt !== 16'd19) begin
            n_fail++;
            $display("FAIL tmo_flags: got tmo=%b err=%0d cmd=%0d expected 1 1 19",
                     o_timeout, o_err_cnt, o_cmd_cnt);
        end
        tick();
        n_tests++;
        if (o_args_valid !== 1'b1 || o_args[0] != KW_SET) begin
            n_fail++;
            $display("FAIL tmo_next_issue: got valid=%b kw=%s expected 1 SET", o_args_valid, o_args[0]);
        end
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        n_tests++;
        if (o_done !== 1'b1 || o_cmd_cnt !== 16'd20 || o_err_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL tmo_retire_next: got done=%b cmd=%0d err=%0d expected 1 20 1",
                     o_done, o_cmd_cnt, o_err_cnt);
        end
    endtask

    task automatic test_ack_at_timeout();
        int vcnt = 0;
        do_reset();
        push_cmd(KW_CHK, 0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (o_args_valid === 1'b1) vcnt++;
        end
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        n_tests++;
        if (vcnt != TMO || o_cmd_cnt !== 16'd1 || o_err_cnt !== 16'd0 ||
            o_timeout !== 1'b0 || o_done !== 1'b1) begin
            n_fail++;
            $display("FAIL ack_at_tmo: got vcnt=%0d cmd=%0d err=%0d tmo=%b done=%b expected 10 1 0 0 1",
                     vcnt, o_cmd_cnt, o_err_cnt, o_timeout, o_done);
        end
    endtask

    task automatic test_back_to_back();
        int issued = 0;
        int done_k = -1;
        push_cmd(KW_SET, 0);
        push_cmd(KW_WTF, 1);
        i_ack = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            // Push the next command on each of the first three FETCH edges.
            if (k == 1 || k == 3 || k == 5) begin
                set_args(KW_CHK, 2 + (k - 1) / 2);
                i_push = 1'b1;
            end
            tick();
            i_push = 1'b0;
            if (o_args_valid === 1'b1) begin
                n_tests++;
                if (o_args[0] != ((issued == 1) ? KW_WTF : ((issued == 0) ? KW_SET : KW_CHK)) ||
                    o_args[1] != $sformatf("%0d_1", issued) || o_args[4] != $sformatf("%0d_4", issued)) begin
                    n_fail++;
                    $display("FAIL b2b_order%0d: got %s %s %s", issued, o_args[0], o_args[1], o_args[4]);
                end
                issued++;
            end
            if (o_done === 1'b1) done_k = k;
        end
        i_ack = 1'b0;
        n_tests++;
        if (issued != 5 || done_k != 10 || o_cmd_cnt !== 16'd6 || o_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_end: got issued=%0d done_k=%0d cmd=%0d empty=%b expected 5 10 6 1",
                     issued, done_k, o_cmd_cnt, o_empty);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        push_cmd(KW_SET, 0);
        push_cmd(KW_SET, 1);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        tick();
        n_tests++;
        if (o_args_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got valid=%b expected 1", o_args_valid);
        end
        rst_n = 1'b0;
        tick();
        n_tests++;
        if (o_args_valid !== 1'b0 || o_cmd_cnt !== 16'd0 || o_err_cnt !== 16'd0 ||
            o_empty !== 1'b1 || o_busy !== 1'b0 || o_args[0] != "") begin
            n_fail++;
            $display("FAIL rstmid_state: got valid=%b cmd=%0d err=%0d empty=%b busy=%b kw='%s'",
                     o_args_valid, o_cmd_cnt, o_err_cnt, o_empty, o_busy, o_args[0]);
        end
        rst_n = 1'b1;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (o_done === 1'b1 || o_busy === 1'b1) done_seen++;
        end
        n_tests++;
        if (done_seen != 0) begin
            n_fail++;
            $display("FAIL rstmid_start_empty: got %0d done/busy cycles expected 0", done_seen);
        end
    endtask

    initial begin
        for (int j = 0; j < ARGS; j++) i_push_args[j] = "";
        test_reset();
        test_basic();
        test_overflow();
        test_timeout();
        test_ack_at_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tb_cmd_sequencer.md
# tb_cmd_sequencer

Testbench-side command issuer that drives the scenario command decoder. It buffers parsed scenario lines (string argument vectors) in a FIFO and presents them one at a time on an args/valid bus. It retires each command on the decoder's ack and flags commands that are never acknowledged. It sits between the scenario file reader and the decoder, on the producing end of the `args`/`args_valid`/`ack` handshake.

## Interface
Parameters:
- `ARGS_NB`, 5: number of string arguments per command; must match the decoder.
- `FIFO_DEPTH`, 16: command buffer depth; power of two, ≥ 2.
- `TIMEOUT_CYCLES`, 1000: maximum cycles a command waits for ack; ≥ 2.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `i_push`  in  1  write one command into the FIFO.
- `i_push_args`  in  string[ARGS_NB]  command to write; `[0]` is the keyword (SET/WTR/WTF/CHK).
- `i_start`  in  1  one-cycle pulse that arms issuing.
- `o_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `o_empty`  out  1  FIFO holds 0 entries.
- `o_args`  out  string[ARGS_NB]  current command presented to the decoder.
- `o_args_valid`  out  1  `o_args` holds a live command.
- `i_ack`  in  1  decoder acknowledge.
- `o_busy`  out  1  sequencer is armed (any state other than IDLE).
- `o_done`  out  1  one-cycle pulse when the armed run drains the FIFO.
- `o_timeout`  out  1  sticky; some command timed out.
- `o_overflow`  out  1  sticky; a push was dropped.
- `o_cmd_cnt`  out  16  commands retired by ack since reset; wraps at 65535→0.
- `o_err_cnt`  out  16  commands retired by timeout; saturates at 65535.

## Operation
- FIFO push: accepted when `i_push && !o_full`, judged on the occupancy at the start of the cycle.
  - A push while full is dropped and sets `o_overflow`, even if a pop happens in the same cycle.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged.
- State machine:
  - **IDLE:** `i_start` moves to FETCH. If the FIFO is empty, stay in IDLE and pulse nothing. `i_start` outside IDLE is ignored.
  - **FETCH:** pop the FIFO head into the `o_args` register, clear the timeout counter, go to ISSUE.
  - **ISSUE:** `o_args_valid`=1 and the counter increments each cycle. Exit when the cycle's condition resolves:
    - `i_ack`=1: retire, increment `o_cmd_cnt`.
    - No ack and counter = `TIMEOUT_CYCLES-1`: retire, set `o_timeout`, increment `o_err_cnt`.
  - **After retire:** go to FETCH if the FIFO is non-empty, else go to IDLE and pulse `o_done`.
- Ack rules:
  - `i_ack` is ignored outside ISSUE.
  - Ack and timeout on the same cycle: ack wins (counts as acknowledged).
  - The decoder holds ack low for WTR, so waits consume timeout budget.
- `o_args` holds its last value after retire; only `o_args_valid` drops.
- Pushes during a run are allowed. A FIFO that is empty at retire ends the run, even if a push lands in that same cycle.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - State goes to IDLE and the FIFO is emptied.
  - `o_args` = all "" and all 1-bit outputs = 0, except `o_empty`=1.
  - Both counters = 0.
  - Reset mid-command drops the command with no count change.
- Latency:
  - `i_start` at edge N (FIFO non-empty) → FETCH at N+1 → `o_args_valid`=1 from N+2.
  - Ack sampled at edge M → valid low at M+1 (FETCH) → next command valid at M+2. There is one bubble cycle between commands.
- `o_done` is high for exactly the cycle after the last retire.
- Timeout: with no ack, valid is high for exactly `TIMEOUT_CYCLES` cycles.
- Flags and counters update on the edge after the causing event.

## Structure
- Package `tb_cmd_pkg` contains:
  - The state enum (IDLE, FETCH, ISSUE).
  - Keyword string constants "SET", "WTR", "WTF", "CHK".
  - Counter width constant (16).
- Sub-module `tb_cmd_fifo` holds the string-vector FIFO.
  - Parameters: `ARGS_NB`, `FIFO_DEPTH`.
  - Ports: push, pop, data in, data out, full, empty.
  - Pointers are one bit wider than the address to distinguish full from empty.
- The top level holds the FSM, timeout counter, flags and counters.

## Test plan
- Reset, then push 3 commands (SET/CHK/SET) with `i_ack` tied high, then `i_start` → valid at cycles +2, +4, +6; `o_cmd_cnt`=3; `o_done` pulses once; `o_empty`=1.
- Push 17 commands into `FIFO_DEPTH`=16 → `o_full`=1 after 16; the 17th push sets `o_overflow`; occupancy stays 16.
- WTR with ack never raised, `TIMEOUT_CYCLES`=10 → valid high 10 cycles; `o_timeout`=1; `o_err_cnt`=1; the next command issues 2 cycles after the drop.
- Ack raised on the exact timeout cycle → `o_cmd_cnt`+1, `o_err_cnt` unchanged, `o_timeout`=0.
- `rst_n` low during ISSUE → the next edge has `o_args_valid`=0, counters 0, FIFO empty; a following `i_start` produces no `o_done`.
- Simultaneous push and pop while a run is in progress → occupancy unchanged, command order preserved (compare `o_args[0..4]` against the pushed sequence).
